// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Arbitrates the single register-file write port between the in-order
//   pipeline writeback (A) and a long-latency result source (B). One
//   requester is granted per cycle. The loser is held by valid/ready. The
//   granted write is registered and reaches the register file one cycle later.
//
//   Optional feature macro: WB_PERF_EN. When it is defined, the block adds
//   o_conflict_cnt, which counts the cycles in which both requests are valid.
//
//   Ports
//     i_clk, i_rst_n         clock; synchronous active-low reset
//     i_a_valid/rd/data      pipeline writeback request; o_a_ready is its grant
//     i_b_valid/rd/data      long-latency request;       o_b_ready is its grant
//     o_rf_wen/waddr/wdata   registered register-file write
//     o_conflict_cnt         both-valid cycle count (WB_PERF_EN only)
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_a_valid,
  input  logic [4:0]      i_a_rd,
  input  logic [XLEN-1:0] i_a_data,
  output logic            o_a_ready,
  input  logic            i_b_valid,
  input  logic [4:0]      i_b_rd,
  input  logic [XLEN-1:0] i_b_data,
  output logic            o_b_ready,
  output logic            o_rf_wen,
  output logic [4:0]      o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata
`ifdef WB_PERF_EN
  ,
  output logic [31:0]     o_conflict_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]      b_wait;
  logic            same_rd;
  logic            b_win;
  logic            a_grant;
  logic            b_grant;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  // A matching nonzero rd means B holds the older instruction. B goes first
  // so that the younger A value is the one left in the register.
  assign same_rd = (i_a_rd == i_b_rd) && (i_a_rd != 5'd0);
  assign b_win   = i_b_valid && (!i_a_valid || same_rd || (b_wait == LIMIT));

  always_comb begin
    a_grant  = 1'b0;
    b_grant  = 1'b0;
    sel_rd   = i_a_rd;
    sel_data = i_a_data;
    if (i_rst_n) begin
      b_grant = b_win;
      a_grant = i_a_valid && !b_win;
    end
    if (b_win) begin
      sel_rd   = i_b_rd;
      sel_data = i_b_data;
    end
  end

  assign o_a_ready = a_grant;
  assign o_b_ready = b_grant;

  // b_wait counts the consecutive cycles in which B is valid but loses.
  // It saturates at LIMIT. When it reaches LIMIT, B wins the next
  // both-valid cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      b_wait <= 4'd0;
    else if (!i_b_valid || b_grant)
      b_wait <= 4'd0;
    else if (b_wait != LIMIT)
      b_wait <= b_wait + 4'd1;
  end

  // Write stage. A grant to x0 consumes the request but suppresses the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rf_wen   <= 1'b0;
      o_rf_waddr <= 5'd0;
      o_rf_wdata <= '0;
    end else begin
      o_rf_wen <= (a_grant || b_grant) && (sel_rd != 5'd0);
      if (a_grant || b_grant) begin
        o_rf_waddr <= sel_rd;
        o_rf_wdata <= sel_data;
      end
    end
  end

`ifdef WB_PERF_EN
  // Wraps naturally at 2^32.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      o_conflict_cnt <= 32'd0;
    else if (i_a_valid && i_b_valid)
      o_conflict_cnt <= o_conflict_cnt + 32'd1;
  end
`endif

endmodule
